// File: rtl/nxm_mode_queue.sv
// Circular-buffer queue with runtime FIFO/LIFO discipline, thresholds, occupancy and sticky errors.
// Read latency 1 cycle; a push when full is dropped (overflow_err), a pop when empty sets underflow_err.
module nxm_mode_queue #(
    parameter int BITWIDTH  = 8,
    parameter int QUEUESIZE = 32,
    parameter int AFULL_TH  = QUEUESIZE - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       mode,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    input  logic [BITWIDTH-1:0]        data_in,
    output logic [BITWIDTH-1:0]        data_out,
    output logic                       data_out_valid,
    output logic [$clog2(QUEUESIZE):0] count,
    output logic                       mode_active,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow_err,
    output logic                       underflow_err
);

    localparam int PW = $clog2(QUEUESIZE);
    localparam int CW = PW + 1;

    logic [BITWIDTH-1:0] r_mem [QUEUESIZE];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [BITWIDTH-1:0] r_dout;
    logic                r_vld;
    logic                r_mode;
    logic                r_ovf;
    logic                r_unf;

    logic                w_empty;
    logic                w_full;
    logic                w_wr_en;
    logic                w_rd_en;
    logic                w_bypass;
    logic                w_wr_adv;
    logic                w_rd_adv;
    logic                w_ovf_evt;
    logic                w_unf_evt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [PW-1:0]       w_wr_addr;
    logic [PW-1:0]       w_rd_addr;
    logic [BITWIDTH-1:0] w_rd_dat;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUESIZE - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == CW'(QUEUESIZE));
        w_wr_en   = 1'b0;
        w_rd_en   = 1'b0;
        w_bypass  = 1'b0;
        w_wr_adv  = 1'b0;
        w_rd_adv  = 1'b0;
        w_ovf_evt = 1'b0;
        w_unf_evt = 1'b0;
        w_cnt_nxt = r_count;
        // LIFO addresses the top of stack directly from the occupancy
        w_wr_addr = r_mode ? r_count[PW-1:0] : r_wr_ptr;
        w_rd_addr = r_mode ? (r_count[PW-1:0] - PW'(1)) : r_rd_ptr;
        if (enable) begin
            if (push && pop) begin
                if (w_empty || r_mode) begin
                    w_bypass = 1'b1;
                end else begin
                    w_wr_en  = 1'b1;
                    w_rd_en  = 1'b1;
                    w_wr_adv = 1'b1;
                    w_rd_adv = 1'b1;
                end
            end else if (push) begin
                if (w_full) begin
                    w_ovf_evt = 1'b1;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_adv  = !r_mode;
                    w_cnt_nxt = r_count + CW'(1);
                end
            end else if (pop) begin
                if (w_empty) begin
                    w_unf_evt = 1'b1;
                end else begin
                    w_rd_en   = 1'b1;
                    w_rd_adv  = !r_mode;
                    w_cnt_nxt = r_count - CW'(1);
                end
            end
        end
    end

    assign w_rd_dat = r_mem[w_rd_addr];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_vld    <= 1'b0;
            r_mode   <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (enable) begin
                if (w_bypass) begin
                    r_dout <= data_in;
                    r_vld  <= 1'b1;
                end else if (w_rd_en) begin
                    r_dout <= w_rd_dat;
                    r_vld  <= 1'b1;
                end
                r_count <= w_cnt_nxt;
                if (w_wr_adv) begin
                    r_wr_ptr <= f_inc(r_wr_ptr);
                end
                if (w_rd_adv) begin
                    r_rd_ptr <= f_inc(r_rd_ptr);
                end
                // Discipline may only change while the queue is empty and nothing is entering
                if (w_empty && !push) begin
                    r_mode <= mode;
                    if (mode) begin
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                    end
                end
                if (err_clr) begin
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                end
                if (w_ovf_evt) begin
                    r_ovf <= 1'b1;
                end
                if (w_unf_evt) begin
                    r_unf <= 1'b1;
                end
            end
        end
    end

    assign data_out       = r_dout;
    assign data_out_valid = r_vld;
    assign count          = r_count;
    assign mode_active    = r_mode;
    assign full           = (r_count == CW'(QUEUESIZE));
    assign empty          = (r_count == '0);
    assign almost_full    = (r_count >= CW'(AFULL_TH));
    assign almost_empty   = (r_count <= CW'(AEMPTY_TH));
    assign overflow_err   = r_ovf;
    assign underflow_err  = r_unf;

endmodule

// File: tb/tb_nxm_mode_queue.sv
// Bench for nxm_mode_queue: vector table with a read-data scoreboard, plus reset and startup sequences.
module tb_nxm_mode_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, mode, push, pop, err_clr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [2:0] count;
    logic       mode_active, full, empty, almost_full, almost_empty;
    logic       overflow_err, underflow_err;

    nxm_mode_queue #(.BITWIDTH(8), .QUEUESIZE(4), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .push(push), .pop(pop),
        .err_clr(err_clr), .data_in(data_in), .data_out(data_out),
        .data_out_valid(data_out_valid), .count(count), .mode_active(mode_active),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, md, ps, pp, clr;
        logic [7:0] din;
        logic       vld;
        logic [7:0] dexp;
        int         cnt;
        logic       mact, ovf, unf;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb[$];
    logic [7:0] exp_hold;
    int         n_pass = 0;
    int         n_total = 0;

    function automatic vec_t mk(logic en, logic md, logic ps, logic pp, logic clr, logic [7:0] din,
                                logic vld, logic [7:0] dexp, int cnt, logic mact, logic ovf, logic unf);
        vec_t v;
        v.en = en; v.md = md; v.ps = ps; v.pp = pp; v.clr = clr; v.din = din;
        v.vld = vld; v.dexp = dexp; v.cnt = cnt; v.mact = mact; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic mact, input logic ovf, input logic unf);
        chk({tag, " count"}, int'(count), cnt);
        chk({tag, " mode_active"}, int'(mode_active), int'(mact));
        chk({tag, " overflow_err"}, int'(overflow_err), int'(ovf));
        chk({tag, " underflow_err"}, int'(underflow_err), int'(unf));
        chk({tag, " full"}, int'(full), int'(cnt == 4));
        chk({tag, " empty"}, int'(empty), int'(cnt == 0));
        chk({tag, " almost_full"}, int'(almost_full), int'(cnt >= 3));
        chk({tag, " almost_empty"}, int'(almost_empty), int'(cnt <= 1));
    endtask

    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        enable = v.en; mode = v.md; push = v.ps; pop = v.pp; err_clr = v.clr; data_in = v.din;
        if (v.vld) sb.push_back(v.dexp);
        @(posedge clk);
        #1;
        chk({tag, " data_out_valid"}, int'(data_out_valid), int'(v.vld));
        if (data_out_valid) begin
            if (sb.size() == 0) begin
                chk({tag, " unexpected output"}, int'(data_out), -1);
            end else begin
                exp_hold = sb.pop_front();
                chk({tag, " data_out"}, int'(data_out), int'(exp_hold));
            end
        end else begin
            chk({tag, " data_out hold"}, int'(data_out), int'(exp_hold));
        end
        chk_state(tag, v.cnt, v.mact, v.ovf, v.unf);
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; mode = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; data_in = '0;
        exp_hold = '0;

        // Wrap-around in FIFO
        tbl.push_back(mk(1,0,1,0,0,8'h11, 0,8'h00, 1,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,8'h22, 0,8'h00, 2,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,8'h33, 0,8'h00, 3,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,8'h44, 0,8'h00, 4,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,8'h00, 1,8'h11, 3,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,8'h00, 1,8'h22, 2,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,8'h55, 0,8'h00, 3,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,8'h66, 0,8'h00, 4,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,8'h00, 1,8'h33, 3,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,8'h00, 1,8'h44, 2,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,8'h00, 1,8'h55, 1,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,8'h00, 1,8'h66, 0,0,0,0));
        // LIFO ordering, underflow, error clear
        tbl.push_back(mk(1,1,0,0,0,8'h00, 0,8'h00, 0,1,0,0));
        tbl.push_back(mk(1,1,1,0,0,8'hA1, 0,8'h00, 1,1,0,0));
        tbl.push_back(mk(1,1,1,0,0,8'hA2, 0,8'h00, 2,1,0,0));
        tbl.push_back(mk(1,1,1,0,0,8'hA3, 0,8'h00, 3,1,0,0));
        tbl.push_back(mk(1,1,0,1,0,8'h00, 1,8'hA3, 2,1,0,0));
        tbl.push_back(mk(1,1,0,1,0,8'h00, 1,8'hA2, 1,1,0,0));
        tbl.push_back(mk(1,1,0,1,0,8'h00, 1,8'hA1, 0,1,0,0));
        tbl.push_back(mk(1,1,0,1,0,8'h00, 0,8'h00, 0,1,0,1));
        tbl.push_back(mk(1,1,0,0,1,8'h00, 0,8'h00, 0,1,0,0));
        // Bypass: LIFO empty, LIFO non-empty, FIFO empty
        tbl.push_back(mk(1,1,1,1,0,8'h7E, 1,8'h7E, 0,1,0,0));
        tbl.push_back(mk(1,1,1,0,0,8'hB1, 0,8'h00, 1,1,0,0));
        tbl.push_back(mk(1,1,1,1,0,8'hB2, 1,8'hB2, 1,1,0,0));
        tbl.push_back(mk(1,1,0,1,0,8'h00, 1,8'hB1, 0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,8'h00, 0,8'h00, 0,0,0,0));
        tbl.push_back(mk(1,0,1,1,0,8'h7E, 1,8'h7E, 0,0,0,0));
        // FIFO full, overflow, push+pop while full
        tbl.push_back(mk(1,0,1,0,0,8'h01, 0,8'h00, 1,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,8'h02, 0,8'h00, 2,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,8'h03, 0,8'h00, 3,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,8'h04, 0,8'h00, 4,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,8'h09, 0,8'h00, 4,0,1,0));
        tbl.push_back(mk(1,0,1,1,0,8'h0A, 1,8'h01, 4,0,1,0));
        tbl.push_back(mk(1,0,0,1,0,8'h00, 1,8'h02, 3,0,1,0));
        tbl.push_back(mk(1,0,0,1,0,8'h00, 1,8'h03, 2,0,1,0));
        tbl.push_back(mk(1,0,0,1,0,8'h00, 1,8'h04, 1,0,1,0));
        tbl.push_back(mk(1,0,0,1,0,8'h00, 1,8'h0A, 0,0,1,0));
        // Mode lock while data is held
        tbl.push_back(mk(1,0,1,0,0,8'h01, 0,8'h00, 1,0,1,0));
        tbl.push_back(mk(1,0,1,0,0,8'h02, 0,8'h00, 2,0,1,0));
        tbl.push_back(mk(1,1,0,0,0,8'h00, 0,8'h00, 2,0,1,0));
        tbl.push_back(mk(1,1,0,1,0,8'h00, 1,8'h01, 1,0,1,0));
        tbl.push_back(mk(1,1,0,1,0,8'h00, 1,8'h02, 0,0,1,0));
        tbl.push_back(mk(1,1,0,0,0,8'h00, 0,8'h00, 0,1,1,0));
        tbl.push_back(mk(1,1,0,0,1,8'h00, 0,8'h00, 0,1,0,0));
        // Set-wins on err_clr, enable gating
        tbl.push_back(mk(1,1,1,0,0,8'hC1, 0,8'h00, 1,1,0,0));
        tbl.push_back(mk(1,1,1,0,0,8'hC2, 0,8'h00, 2,1,0,0));
        tbl.push_back(mk(1,1,1,0,0,8'hC3, 0,8'h00, 3,1,0,0));
        tbl.push_back(mk(1,1,1,0,0,8'hC4, 0,8'h00, 4,1,0,0));
        tbl.push_back(mk(1,1,1,0,1,8'hC5, 0,8'h00, 4,1,1,0));
        tbl.push_back(mk(0,1,0,0,1,8'h00, 0,8'h00, 4,1,1,0));
        tbl.push_back(mk(0,1,1,1,0,8'h5A, 0,8'h00, 4,1,1,0));
        tbl.push_back(mk(1,1,0,0,1,8'h00, 0,8'h00, 4,1,0,0));
        tbl.push_back(mk(1,1,0,1,0,8'h00, 1,8'hC4, 3,1,0,0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset data_out", int'(data_out), 0);
        chk("reset data_out_valid", int'(data_out_valid), 0);
        chk_state("reset", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Asynchronous reset away from any clock edge while holding 3 entries
        @(negedge clk);
        enable = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async rst data_out", int'(data_out), 0);
        chk("async rst data_out_valid", int'(data_out_valid), 0);
        chk_state("async rst", 0, 1'b0, 1'b0, 1'b0);
        exp_hold = '0;
        @(negedge clk);
        rst = 1'b1;
        apply(mk(1,0,1,0,0,8'h5A, 0,8'h00, 1,0,0,0), 100);
        apply(mk(1,0,0,1,0,8'h00, 1,8'h5A, 0,0,0,0), 101);

        chk("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
